// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared text-mode geometry, arbiter state encoding and RAM slot owner tags.
package vga_text_pkg;
    localparam int TextCols = 64;
    localparam int TextRows = 32;
    localparam int TEXT_ADDR_W = 11;
    localparam int TEXT_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, CPU_WR, CPU_RD, CLEAR} state_t;
    typedef enum logic [1:0] {NONE, VGA, CPU, CLR} tag_t;
endpackage

// File: rtl/text_ram_arbiter_if.sv
// text_ram_arbiter_if: VGA fetch, CPU bus, clear control and text RAM port bundle.
//   slave  : arbiter view (requests in, responses and RAM port out)
//   master : environment view (VGA engine, CPU decode, RAM model)
interface text_ram_arbiter_if
    import vga_text_pkg::*;
#(
    parameter int ADDR_W = TEXT_ADDR_W,
    parameter int DATA_W = TEXT_DATA_W
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_valid;
    logic [DATA_W-1:0] vga_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              clr_start;
    logic              clr_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, clr_start, ram_rdata,
        output vga_valid, vga_rdata, cpu_ack, cpu_rdata, clr_busy, ram_addr, ram_we, ram_wdata
    );
    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, clr_start, ram_rdata,
        input  vga_valid, vga_rdata, cpu_ack, cpu_rdata, clr_busy, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/range_counter.sv
// range_counter: saturating 0..MAX address walker, present only with TEXT_CLEAR_EN.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous return to 0
//   en         : advance one step
//   count      : current value
//   wrap       : en while at MAX (the final step of the walk)
`ifdef TEXT_CLEAR_EN
module range_counter #(
    parameter int WIDTH = 11,
    parameter int MAX   = 2047
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    assign wrap = en && count == WIDTH'(MAX);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (en && !wrap) count <= count + 1'b1;
    end
endmodule
`endif

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares the single-port text RAM between VGA fetch (absolute priority), clear engine and CPU.
//   clk25MHz : pixel clock
//   reset    : asynchronous active-high reset
//   bus      : text_ram_arbiter_if.slave (VGA fetch, CPU bus, clear control, RAM port)
//   TEXT_CLEAR_EN defined adds the clear engine; otherwise clr_start is ignored and clr_busy is 0.
module text_ram_arbiter
    import vga_text_pkg::*;
#(
    parameter int ADDR_W = TEXT_ADDR_W,
    parameter int DATA_W = TEXT_DATA_W,
    parameter int DEPTH = TextCols * TextRows,
    parameter logic [DATA_W-1:0] CLR_CHAR = 8'h20
) (
    input  logic clk25MHz,
    input  logic reset,
    text_ram_arbiter_if.slave bus
);
    state_t state, state_nxt;
    tag_t grant, tag_q0, tag_q1;
    logic ack_nxt, clr_req, clr_go, clr_wrap;
    logic [DATA_W-1:0] rdata_nxt;
    logic [ADDR_W-1:0] clr_addr;
`ifdef TEXT_CLEAR_EN
    assign clr_req = bus.clr_start;
    range_counter #(.WIDTH(ADDR_W), .MAX(DEPTH - 1)) u_clr_cnt (
        .clk(clk25MHz),
        .reset(reset),
        .clear(clr_go),
        .en(grant == CLR),
        .count(clr_addr),
        .wrap(clr_wrap)
    );
    assign bus.clr_busy = state == CLEAR;
`else
    logic unused_clr;
    assign clr_req = 1'b0;
    assign clr_addr = '0;
    assign clr_wrap = 1'b0;
    assign bus.clr_busy = 1'b0;
    assign unused_clr = ^{bus.clr_start, clr_go, DEPTH[0]};
`endif
    // The tag pipe lines up with the RAM read latency, so tag_q1 names the owner of ram_rdata.
    assign bus.vga_valid = tag_q1 == VGA;
    assign bus.vga_rdata = tag_q1 == VGA ? bus.ram_rdata : '0;
    always_comb begin
        grant = NONE;
        state_nxt = state;
        ack_nxt = 1'b0;
        rdata_nxt = '0;
        clr_go = 1'b0;
        // A CPU grant is withheld during its own ack cycle, since cpu_req is still high then.
        if (bus.vga_req) grant = VGA;
        else if (state == CLEAR) grant = CLR;
        else if (state == IDLE && bus.cpu_req && !bus.cpu_ack && !clr_req) grant = CPU;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    clr_go = 1'b1;
                end else if (grant == CPU) state_nxt = bus.cpu_we ? CPU_WR : CPU_RD;
            end
            CPU_WR: begin
                state_nxt = IDLE;
                ack_nxt = 1'b1;
            end
            CPU_RD: begin
                if (tag_q1 == CPU) begin
                    state_nxt = IDLE;
                    ack_nxt = 1'b1;
                    rdata_nxt = bus.ram_rdata;
                end
            end
            CLEAR: state_nxt = clr_wrap ? IDLE : CLEAR;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk25MHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tag_q0 <= NONE;
            tag_q1 <= NONE;
            bus.cpu_ack <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.ram_addr <= '0;
            bus.ram_we <= 1'b0;
            bus.ram_wdata <= '0;
        end else begin
            state <= state_nxt;
            tag_q0 <= grant;
            tag_q1 <= tag_q0;
            bus.cpu_ack <= ack_nxt;
            bus.cpu_rdata <= rdata_nxt;
            bus.ram_addr <= grant == VGA ? bus.vga_addr : grant == CLR ? clr_addr : grant == CPU ? bus.cpu_addr : bus.ram_addr;
            bus.ram_we <= grant == CLR || (grant == CPU && bus.cpu_we);
            bus.ram_wdata <= grant == CLR ? CLR_CHAR : grant == CPU ? bus.cpu_wdata : bus.ram_wdata;
        end
    end
endmodule
